// File: rtl/tmr_pkg.sv
// Shared definitions for the distributed-TMR register pipeline: replica count,
// replica index type and the bitwise majority function used by every voter.
package tmr_pkg;

  localparam int unsigned NREP = 3;

  typedef logic [1:0] rep_idx_t;

  localparam rep_idx_t INJ_NONE = 2'd3;

  // Callers zero-extend to MAJ_W and truncate the result, so vectors up to
  // MAJ_W bits can share this one function.
  localparam int unsigned MAJ_W = 256;

  function automatic logic [MAJ_W-1:0] maj3(input logic [MAJ_W-1:0] a,
                                            input logic [MAJ_W-1:0] b,
                                            input logic [MAJ_W-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tmr_voter.sv
// Three-input bitwise majority voter with a per-replica disagreement flag.
// Each use site gets its own instance so the redundancy survives synthesis.
module tmr_voter
  import tmr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] voted,
  output logic [NREP-1:0]  mismatch
);

  assign voted = WIDTH'(maj3(MAJ_W'(a), MAJ_W'(b), MAJ_W'(c)));

  assign mismatch = {(c != voted), (b != voted), (a != voted)};

endmodule

// File: rtl/tmr_reg_pipe.sv
// Distributed-TMR pipeline: STAGES triplicated {valid,data} register stages with
// per-replica inter-stage voters, hold/self-scrub mode, mismatch reporting and injection.
module tmr_reg_pipe
  import tmr_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             hold,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       err_replica,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_clr,
  input  logic             inj_en,
  input  logic [1:0]       inj_sel,
  input  logic [WIDTH-1:0] inj_mask
);

  localparam int unsigned DW = WIDTH + 1;

  logic [DW-1:0]   rep_q [STAGES][NREP];
  logic [NREP-1:0] inj_hit;
  logic [DW-1:0]   out_vote;
  logic [NREP-1:0] last_mm;

  always_comb begin
    inj_hit = '0;
    for (int unsigned r = 0; r < NREP; r++) begin
      inj_hit[r] = inj_en && (inj_sel != INJ_NONE) && (inj_sel == rep_idx_t'(r));
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    for (genvar r = 0; r < NREP; r++) begin : g_rep
      logic [DW-1:0]   q;
      logic [DW-1:0]   d;
      logic [DW-1:0]   hold_v;
      logic [DW-1:0]   shift_v;
      logic [DW-1:0]   flip;
      logic [NREP-1:0] unused_hold_mm;

      tmr_voter #(.WIDTH(DW)) u_hold_voter (
        .a        (rep_q[k][0]),
        .b        (rep_q[k][1]),
        .c        (rep_q[k][2]),
        .voted    (hold_v),
        .mismatch (unused_hold_mm)
      );

      if (k == 0) begin : g_in
        assign shift_v = {in_valid, in_data};
        // Injection lands after the hold/shift mux so it also hits the self-scrub path.
        assign flip    = {1'b0, {WIDTH{inj_hit[r]}} & inj_mask};
      end else begin : g_vote
        logic [NREP-1:0] unused_shift_mm;

        tmr_voter #(.WIDTH(DW)) u_shift_voter (
          .a        (rep_q[k-1][0]),
          .b        (rep_q[k-1][1]),
          .c        (rep_q[k-1][2]),
          .voted    (shift_v),
          .mismatch (unused_shift_mm)
        );
        assign flip = '0;
      end

      assign d = (hold ? hold_v : shift_v) ^ flip;

      always_ff @(posedge clk) begin
        if (rst) begin
          q <= '0;
        end else begin
          q <= d;
        end
      end

      assign rep_q[k][r] = q;
    end
  end

  tmr_voter #(.WIDTH(DW)) u_out_voter (
    .a        (rep_q[STAGES-1][0]),
    .b        (rep_q[STAGES-1][1]),
    .c        (rep_q[STAGES-1][2]),
    .voted    (out_vote),
    .mismatch (last_mm)
  );

  assign {out_valid, out_data} = out_vote;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_replica <= '0;
      err_count   <= '0;
    end else begin
      err_replica <= last_mm;
      if (err_clr) begin
        err_count <= '0;
      end else if ((|last_mm) && (err_count != '1)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule
